// File: rtl/c_regfile_fifo_ctrl.sv
// c_regfile_fifo_ctrl
//   Pointer and flow-control engine that turns a single-write/single-read
//   register file into a circular FIFO. Holds only head, tail, occupancy
//   and sticky error state; all data lives in the external register file.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   push, pop          producer write request / consumer head removal
//   error_clear        clears the sticky error flags
//   write_active       high whenever a write is accepted this cycle
//   write_enable       register file write strobe
//   write_address      tail pointer (register file write port)
//   read_address       head pointer (register file read port, combinational)
//   count              current occupancy
//   empty, full        count == 0 / count == depth
//   almost_empty       count <= almost_empty_level
//   almost_full        count >= almost_full_level
//   errors             sticky flags: [0] overflow, [1] underflow
module c_regfile_fifo_ctrl #(
    parameter int depth              = 8,
    parameter int almost_full_level  = 6,
    parameter int almost_empty_level = 2,
    localparam int addr_width        = $clog2(depth),
    localparam int count_width       = $clog2(depth + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   error_clear,
    output logic                   write_active,
    output logic                   write_enable,
    output logic [addr_width-1:0]  write_address,
    output logic [addr_width-1:0]  read_address,
    output logic [count_width-1:0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [1:0]             errors
);

    // Elaboration-time parameter sanity checks.
    if (depth < 2) begin : g_bad_depth
        $fatal(1, "c_regfile_fifo_ctrl: depth must be >= 2");
    end
    if (almost_full_level < 1 || almost_full_level > depth) begin : g_bad_af
        $fatal(1, "c_regfile_fifo_ctrl: almost_full_level must be in 1..depth");
    end
    if (almost_empty_level < 0 || almost_empty_level > depth - 1) begin : g_bad_ae
        $fatal(1, "c_regfile_fifo_ctrl: almost_empty_level must be in 0..depth-1");
    end

    localparam logic [addr_width-1:0]  last_ptr = addr_width'(depth - 1);
    localparam logic [count_width-1:0] cnt_full = count_width'(depth);
    localparam logic [count_width-1:0] cnt_af   = count_width'(almost_full_level);
    localparam logic [count_width-1:0] cnt_ae   = count_width'(almost_empty_level);

    logic [addr_width-1:0]  head, tail;
    logic [addr_width-1:0]  head_nxt, tail_nxt;
    logic [count_width-1:0] count_q, count_nxt;
    logic [1:0]             err_q, err_nxt;
    logic                   pop_ok, push_ok;

    assign empty        = (count_q == '0);
    assign full         = (count_q == cnt_full);
    assign almost_empty = (count_q <= cnt_ae);
    assign almost_full  = (count_q >= cnt_af);

    // A push into a full FIFO is still legal when the head leaves in the
    // same cycle: tail == head, and the old entry is read before the write.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign write_enable  = push_ok;
    assign write_active  = push_ok;
    assign write_address = tail;
    assign read_address  = head;
    assign count         = count_q;
    assign errors        = err_q;

    always_comb begin
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count_q;
        err_nxt   = err_q;

        // Explicit wrap so non-power-of-two depths never touch address depth.
        if (pop_ok)  head_nxt = (head == last_ptr) ? '0 : head + 1'b1;
        if (push_ok) tail_nxt = (tail == last_ptr) ? '0 : tail + 1'b1;

        if (push_ok && !pop_ok)      count_nxt = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_nxt = count_q - 1'b1;

        // Clear first so a same-cycle new error still sets its flag.
        if (error_clear) err_nxt = 2'b00;
        if (push && full && !pop_ok) err_nxt[0] = 1'b1;
        if (pop && empty)            err_nxt[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            err_q   <= 2'b00;
        end else begin
            head    <= head_nxt;
            tail    <= tail_nxt;
            count_q <= count_nxt;
            err_q   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_c_regfile_fifo_ctrl.sv
// Scoreboard bench: a queue-based FIFO model produces the expected view of
// each cycle, a separate monitor compares it with whichever DUT is active.
// Two instances: depth 8 (levels 6/2) and depth 5 (levels 4/1).
module tb_c_regfile_fifo_ctrl;

    typedef struct {
        int         id;
        bit         we;
        int         wa;
        int         ra;
        int         cnt;
        bit         emp;
        bit         ful;
        bit         ae;
        bit         af;
        bit [1:0]   err;
        bit         hv;
        logic [31:0] hd;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] psh = '0, pp = '0, ec = '0;
    logic [31:0] wdata = '0;

    logic       wact0, we0, emp0, ful0, ae0, af0;
    logic [2:0] wa0, ra0;
    logic [3:0] cnt0;
    logic [1:0] err0;
    logic       wact1, we1, emp1, ful1, ae1, af1;
    logic [2:0] wa1, ra1;
    logic [2:0] cnt1;
    logic [1:0] err1;

    c_regfile_fifo_ctrl #(.depth(8), .almost_full_level(6), .almost_empty_level(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .push(psh[0]), .pop(pp[0]), .error_clear(ec[0]),
        .write_active(wact0), .write_enable(we0), .write_address(wa0), .read_address(ra0),
        .count(cnt0), .empty(emp0), .full(ful0), .almost_empty(ae0), .almost_full(af0),
        .errors(err0));

    c_regfile_fifo_ctrl #(.depth(5), .almost_full_level(4), .almost_empty_level(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .push(psh[1]), .pop(pp[1]), .error_clear(ec[1]),
        .write_active(wact1), .write_enable(we1), .write_address(wa1), .read_address(ra1),
        .count(cnt1), .empty(emp1), .full(ful1), .almost_empty(ae1), .almost_full(af1),
        .errors(err1));

    always #5 clk = ~clk;

    // Register file stand-in, written by whichever controller is active.
    logic [31:0] rf [8];
    always @(posedge clk) begin
        if (we0)      rf[wa0] <= wdata;
        else if (we1) rf[wa1] <= wdata;
    end

    int   ntests = 0;
    int   nfail  = 0;
    rec_t expq[$];

    // Reference model state
    int          cur = 0;
    int          dep = 8, afl = 6, ael = 2;
    logic [31:0] mq[$];
    int          mhead = 0, mtail = 0;
    bit [1:0]    merr = 2'b00;

    function automatic rec_t actual(int id);
        rec_t a;
        if (id == 0) begin
            a.we = we0 & wact0; a.wa = wa0; a.ra = ra0; a.cnt = cnt0;
            a.emp = emp0; a.ful = ful0; a.ae = ae0; a.af = af0; a.err = err0;
            a.hd = rf[ra0];
        end else begin
            a.we = we1 & wact1; a.wa = wa1; a.ra = ra1; a.cnt = cnt1;
            a.emp = emp1; a.ful = ful1; a.ae = ae1; a.af = af1; a.err = err1;
            a.hd = rf[ra1];
        end
        a.id = id; a.hv = 1'b0;
        return a;
    endfunction

    // One stimulus cycle: expectation from current model state, then advance.
    task automatic cycle(input bit p, input bit o, input bit c);
        rec_t e;
        int   n;
        bit   m_empty, m_full, pok, wok;
        @(negedge clk);
        n = mq.size();
        m_empty = (n == 0);
        m_full  = (n == dep);
        pok = o && !m_empty;
        wok = p && (!m_full || pok);
        wdata = $urandom;
        psh = '0; pp = '0; ec = '0;
        psh[cur] = p; pp[cur] = o; ec[cur] = c;
        e.id = cur; e.we = wok; e.wa = mtail; e.ra = mhead; e.cnt = n;
        e.emp = m_empty; e.ful = m_full; e.ae = (n <= ael); e.af = (n >= afl);
        e.err = merr; e.hv = !m_empty; e.hd = m_empty ? 32'h0 : mq[0];
        expq.push_back(e);
        if (c) merr = 2'b00;
        if (p && m_full && !pok) merr[0] = 1'b1;
        if (o && m_empty) merr[1] = 1'b1;
        if (pok) begin void'(mq.pop_front()); mhead = (mhead + 1) % dep; end
        if (wok) begin mq.push_back(wdata); mtail = (mtail + 1) % dep; end
    endtask

    // Reset pulsed between edges; outputs must react before the next edge.
    task automatic reset_pulse();
        rec_t a;
        @(negedge clk);
        psh = '0; pp = '0; ec = '0;
        #1 reset_n = 1'b0;
        #2;
        for (int id = 0; id < 2; id++) begin
            a = actual(id);
            ntests++;
            if (a.we || a.wa != 0 || a.ra != 0 || a.cnt != 0 || !a.emp || a.ful ||
                !a.ae || a.af || a.err != 2'b00) begin
                nfail++;
                $display("FAIL reset_async dut%0d: got we=%0d wa=%0d ra=%0d cnt=%0d emp=%0d ful=%0d ae=%0d af=%0d err=%b, want all idle/empty",
                         id, a.we, a.wa, a.ra, a.cnt, a.emp, a.ful, a.ae, a.af, a.err);
            end
        end
        #1 reset_n = 1'b1;
        mq.delete(); mhead = 0; mtail = 0; merr = 2'b00;
    endtask

    // Monitor: pops one expectation per cycle and compares.
    initial begin
        rec_t e, a;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a = actual(e.id);
                ntests++;
                if (a.we != e.we || a.wa != e.wa || a.ra != e.ra || a.cnt != e.cnt ||
                    a.emp != e.emp || a.ful != e.ful || a.ae != e.ae || a.af != e.af ||
                    a.err != e.err) begin
                    nfail++;
                    $display("FAIL ctrl dut%0d @%0t: got we=%0d wa=%0d ra=%0d cnt=%0d e/f=%0d%0d ae/af=%0d%0d err=%b, want we=%0d wa=%0d ra=%0d cnt=%0d e/f=%0d%0d ae/af=%0d%0d err=%b",
                             e.id, $time, a.we, a.wa, a.ra, a.cnt, a.emp, a.ful, a.ae, a.af, a.err,
                             e.we, e.wa, e.ra, e.cnt, e.emp, e.ful, e.ae, e.af, e.err);
                end
                if (e.hv) begin
                    ntests++;
                    if (a.hd !== e.hd) begin
                        nfail++;
                        $display("FAIL head_data dut%0d @%0t: got %h, want %h", e.id, $time, a.hd, e.hd);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // depth 8 instance
        cur = 0; dep = 8; afl = 6; ael = 2;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cycle(0, 0, 0);                            // reset state
        repeat (8) cycle(1, 0, 0);                 // fill: wa 0..7, af at 6, full
        cycle(1, 0, 0);                            // overflow rejected
        cycle(0, 0, 1);                            // errors=01 visible, clear
        cycle(0, 0, 0);                            // errors back to 00
        repeat (3) cycle(1, 1, 0);                 // full push+pop, old data read
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5);
        for (int i = 0; i < 8 && mq.size() > 0; i++) cycle(0, 1, 0);
        repeat (4) cycle(1, 0, 0);
        cycle(0, 1, 0);                            // count 3, pointers moved
        cycle(0, 0, 0);
        reset_pulse();
        cycle(1, 1, 0);                            // empty push+pop: write addr 0
        cycle(0, 0, 0);                            // count 1, errors 10, ra 0
        cycle(0, 0, 1);
        cycle(1, 1, 0);                            // head data visible next cycle
        cycle(0, 0, 0);

        // depth 5 instance: wrap 4 -> 0
        cur = 1; dep = 5; afl = 4; ael = 1;
        reset_pulse();
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 0);
            cycle(i % 3 == 2, 1, 0);
        end
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
        repeat (6) cycle(1, 0, 0);                 // drive to full + overflow
        cycle(0, 0, 0);

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        #3;
        ntests++;
        if (expq.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d expectations left, want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
